// File: rtl/cdb_pkg.sv
// ----------------------------------------------------------------------------
// cdb_pkg
// Types and constants shared by the common data bus (CDB) arbiter, the ROB and
// the reservation stations.
//   - CDB_TAG_W / CDB_DATA_W : default tag and result widths
//   - TAG_*                  : reservation-station tag encoding (TAG_NOTAG = idle)
//   - src_e                  : CDB sources in round-robin order (add, mult, ld)
//   - SRC_TAG_LO/HI          : legal tag range for each source, indexed by src_e
//   - next_src()             : round-robin successor of a source
// ----------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 64;

    localparam logic [CDB_TAG_W-1:0] TAG_NOTAG  = 4'd0;
    localparam logic [CDB_TAG_W-1:0] TAG_ADD_1  = 4'd1;
    localparam logic [CDB_TAG_W-1:0] TAG_ADD_2  = 4'd2;
    localparam logic [CDB_TAG_W-1:0] TAG_ADD_3  = 4'd3;
    localparam logic [CDB_TAG_W-1:0] TAG_MULT_1 = 4'd4;
    localparam logic [CDB_TAG_W-1:0] TAG_MULT_2 = 4'd5;
    localparam logic [CDB_TAG_W-1:0] TAG_LD_1   = 4'd6;
    localparam logic [CDB_TAG_W-1:0] TAG_LD_2   = 4'd7;
    localparam logic [CDB_TAG_W-1:0] TAG_LD_3   = 4'd8;
    localparam logic [CDB_TAG_W-1:0] TAG_ST_1   = 4'd9;
    localparam logic [CDB_TAG_W-1:0] TAG_ST_2   = 4'd10;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        SRC_ADD  = 2'd0,
        SRC_MULT = 2'd1,
        SRC_LD   = 2'd2
    } src_e;

    // Inclusive legal tag range per source, indexed by src_e.
    localparam int SRC_TAG_LO [NUM_SRC] = '{int'(TAG_ADD_1), int'(TAG_MULT_1), int'(TAG_LD_1)};
    localparam int SRC_TAG_HI [NUM_SRC] = '{int'(TAG_ADD_3), int'(TAG_MULT_2), int'(TAG_LD_3)};

    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_ADD:  return SRC_MULT;
            SRC_MULT: return SRC_LD;
            default:  return SRC_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cdb_slot.sv
// ----------------------------------------------------------------------------
// cdb_slot
// Single-entry holding slot between one functional unit and the CDB arbiter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 discard the held result and any offer this cycle
//   in_valid/tag/data     result offered by the functional unit
//   in_ready              slot can take a result this cycle
//   grant                 arbiter is broadcasting this slot's content this cycle
//   full, tag, data       current slot content
//   tag_bad               an offer with an out-of-range tag was dropped this cycle
// ----------------------------------------------------------------------------
module cdb_slot #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4,
    parameter int TAG_LO = 1,
    parameter int TAG_HI = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              grant,
    output logic              full,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data,
    output logic              tag_bad
);

    logic              full_q, full_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tag_legal;
    logic              load;

    always_comb begin
        tag_legal = (int'(in_tag) >= TAG_LO) && (int'(in_tag) <= TAG_HI);
        // A slot that is being granted this cycle empties at the edge, so it
        // can take the next result at the same edge.
        in_ready  = rst_n & ~flush & (~full_q | grant);
        load      = in_valid & in_ready & tag_legal;
        tag_bad   = in_valid & in_ready & ~tag_legal;

        full_d = full_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            tag_d  = in_tag;
            data_d = in_data;
        end else if (grant) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign tag  = tag_q;
    assign data = data_q;

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Collects results from the adder, multiplier and load unit into one holding
// slot each and broadcasts at most one per cycle on the CDB, round-robin in
// the order add, mult, ld.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   CTRL_flush                          drop all pending results (from the ROB)
//   {add,mult,ld}_valid/tag/data/ready  per-source result handshake
//   cdb_id, cdb_data                    registered broadcast; cdb_id = notag when idle
//   tag_err                             sticky: an out-of-range tag was offered
// ----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CTRL_flush,
    input  logic              add_valid,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_data,
    output logic              add_ready,
    input  logic              mult_valid,
    input  logic [TAG_W-1:0]  mult_tag,
    input  logic [DATA_W-1:0] mult_data,
    output logic              mult_ready,
    input  logic              ld_valid,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [TAG_W-1:0]  cdb_id,
    output logic [DATA_W-1:0] cdb_data,
    output logic              tag_err
);

    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] slot_full;
    logic [NUM_SRC-1:0] slot_bad;
    logic [NUM_SRC-1:0] grant;
    logic [TAG_W-1:0]   src_tag  [NUM_SRC];
    logic [DATA_W-1:0]  src_data [NUM_SRC];
    logic [TAG_W-1:0]   slot_tag [NUM_SRC];
    logic [DATA_W-1:0]  slot_data[NUM_SRC];

    src_e              ptr_q, ptr_d;
    src_e              cand;
    src_e              gnt_idx;
    logic              gnt_any;
    logic [TAG_W-1:0]  cdb_id_q, cdb_id_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              tag_err_q, tag_err_d;

    assign src_valid   = {ld_valid, mult_valid, add_valid};
    assign src_tag[0]  = add_tag;
    assign src_tag[1]  = mult_tag;
    assign src_tag[2]  = ld_tag;
    assign src_data[0] = add_data;
    assign src_data[1] = mult_data;
    assign src_data[2] = ld_data;

    assign add_ready  = src_ready[0];
    assign mult_ready = src_ready[1];
    assign ld_ready   = src_ready[2];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            cdb_slot #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W),
                .TAG_LO (SRC_TAG_LO[gi]),
                .TAG_HI (SRC_TAG_HI[gi])
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (CTRL_flush),
                .in_valid (src_valid[gi]),
                .in_tag   (src_tag[gi]),
                .in_data  (src_data[gi]),
                .in_ready (src_ready[gi]),
                .grant    (grant[gi]),
                .full     (slot_full[gi]),
                .tag      (slot_tag[gi]),
                .data     (slot_data[gi]),
                .tag_bad  (slot_bad[gi])
            );
        end
    endgenerate

    // Round-robin pick: scan from the pointer, first full slot wins. A flush
    // suppresses the grant so nothing pending leaks onto the bus.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        if (!CTRL_flush) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!gnt_any && slot_full[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
                cand = next_src(cand);
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end

        ptr_d      = ptr_q;
        cdb_id_d   = TAG_NOTAG;
        cdb_data_d = cdb_data_q;
        tag_err_d  = tag_err_q | (|slot_bad);
        if (CTRL_flush) begin
            ptr_d = SRC_ADD;
        end else if (gnt_any) begin
            ptr_d      = next_src(gnt_idx);
            cdb_id_d   = slot_tag[gnt_idx];
            cdb_data_d = slot_data[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= SRC_ADD;
            cdb_id_q   <= TAG_NOTAG;
            cdb_data_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            cdb_id_q   <= cdb_id_d;
            cdb_data_q <= cdb_data_d;
            tag_err_q  <= tag_err_d;
        end
    end

    assign cdb_id   = cdb_id_q;
    assign cdb_data = cdb_data_q;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: table of single-result vectors, hand
// sequences for contention / fairness / flush / mid-operation reset, and a
// randomized run compared against a per-source pending-result model.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int DW = 64;
    localparam int TW = 4;
    localparam int LO [3] = '{1, 4, 6};
    localparam int HI [3] = '{3, 5, 8};

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                fl    = 1'b0;
    logic [2:0]          vld   = '0;
    logic [2:0][TW-1:0]  tg    = '0;
    logic [2:0][DW-1:0]  dat   = '0;
    wire  [2:0]          rdy;
    wire  [TW-1:0]       cdb_id;
    wire  [DW-1:0]       cdb_data;
    wire                 tag_err;

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CTRL_flush (fl),
        .add_valid  (vld[0]),
        .add_tag    (tg[0]),
        .add_data   (dat[0]),
        .add_ready  (rdy[0]),
        .mult_valid (vld[1]),
        .mult_tag   (tg[1]),
        .mult_data  (dat[1]),
        .mult_ready (rdy[1]),
        .ld_valid   (vld[2]),
        .ld_tag     (tg[2]),
        .ld_data    (dat[2]),
        .ld_ready   (rdy[2]),
        .cdb_id     (cdb_id),
        .cdb_data   (cdb_data),
        .tag_err    (tag_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one pending result per source plus the next source
    // to favour.
    bit            m_pend [3];
    logic [TW-1:0] m_tag  [3];
    logic [DW-1:0] m_data [3];
    int            m_rr;
    logic [TW-1:0] m_id;
    logic [DW-1:0] m_dout;
    bit            m_err;

    logic [2:0]    acc;
    logic [TW-1:0] obs_id;
    logic [DW-1:0] obs_data;

    typedef struct {
        int            src;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [TW-1:0] exp_id;
        bit            exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input int s, input logic [TW-1:0] t);
        return (int'(t) >= LO[s]) && (int'(t) <= HI[s]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) m_pend[s] = 1'b0;
        m_rr   = 0;
        m_id   = '0;
        m_dout = '0;
        m_err  = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check ready, predict the
    // effect of the rising edge, then check the registered outputs after it.
    task automatic cycle(input logic [2:0] v, input logic [2:0][TW-1:0] t,
                         input logic [2:0][DW-1:0] d, input logic f);
        int         g;
        logic [2:0] er;
        @(negedge clk);
        vld = v; tg = t; dat = d; fl = f;
        #1;
        g = -1;
        if (!f) begin
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (m_rr + k) % 3;
                if (g < 0 && m_pend[s]) g = s;
            end
        end
        for (int s = 0; s < 3; s++) er[s] = !f && (!m_pend[s] || g == s);
        check("ready", {61'd0, rdy}, {61'd0, er});
        acc = '0;
        if (f) begin
            for (int s = 0; s < 3; s++) m_pend[s] = 1'b0;
            m_rr = 0;
            m_id = '0;
        end else begin
            if (g >= 0) begin
                m_id      = m_tag[g];
                m_dout    = m_data[g];
                m_pend[g] = 1'b0;
                m_rr      = (g + 1) % 3;
            end else begin
                m_id = '0;
            end
            for (int s = 0; s < 3; s++) begin
                if (v[s] && er[s]) begin
                    if (legal(s, t[s])) begin
                        m_pend[s] = 1'b1;
                        m_tag[s]  = t[s];
                        m_data[s] = d[s];
                        acc[s]    = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("cdb_id", {60'd0, cdb_id}, {60'd0, m_id});
        check("cdb_data", cdb_data, m_dout);
        check("tag_err", {63'd0, tag_err}, {63'd0, m_err});
        obs_id   = cdb_id;
        obs_data = cdb_data;
    endtask

    task automatic idle();
        cycle(3'b000, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vld = '0; fl = 1'b0;
        #1;
        check("rst_ready", {61'd0, rdy}, 64'd0);
        check("rst_cdb_id", {60'd0, cdb_id}, 64'd0);
        check("rst_cdb_data", cdb_data, 64'd0);
        check("rst_tag_err", {63'd0, tag_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [2:0]         v;
        logic [2:0][TW-1:0] t;
        logic [2:0][DW-1:0] d;
        int                 j, ld_acc, ld_b, ld_want;
        logic [DW-1:0]      got [$];

        tbl[0]  = '{0, 4'd2, 64'h1234,             4'd2, 1'b0};
        tbl[1]  = '{0, 4'd1, 64'hdead_beef,        4'd1, 1'b0};
        tbl[2]  = '{0, 4'd3, 64'hffff_ffff_ffff_ffff, 4'd3, 1'b0};
        tbl[3]  = '{0, 4'd0, 64'h11,               4'd0, 1'b1};
        tbl[4]  = '{0, 4'd4, 64'h22,               4'd0, 1'b1};
        tbl[5]  = '{1, 4'd4, 64'h4444,             4'd4, 1'b0};
        tbl[6]  = '{1, 4'd5, 64'h5555_0000_5555,   4'd5, 1'b0};
        tbl[7]  = '{1, 4'd9, 64'h99,               4'd0, 1'b1};
        tbl[8]  = '{1, 4'd3, 64'h33,               4'd0, 1'b1};
        tbl[9]  = '{2, 4'd6, 64'h6666,             4'd6, 1'b0};
        tbl[10] = '{2, 4'd8, 64'h8000_0000_0000_0008, 4'd8, 1'b0};
        tbl[11] = '{2, 4'd5, 64'h55,               4'd0, 1'b1};
        tbl[12] = '{2, 4'd9, 64'h99,               4'd0, 1'b1};

        model_reset();

        // Single-result vectors, each from a fresh reset.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            v = '0; t = '0; d = '0;
            v[tbl[i].src] = 1'b1;
            t[tbl[i].src] = tbl[i].tag;
            d[tbl[i].src] = tbl[i].data;
            cycle(v, t, d, 1'b0);
            idle();
            check("vec_id", {60'd0, obs_id}, {60'd0, tbl[i].exp_id});
            if (tbl[i].exp_id != 0) check("vec_data", obs_data, tbl[i].data);
            check("vec_err", {63'd0, tag_err}, {63'd0, tbl[i].exp_err});
            idle();
            check("vec_id_after", {60'd0, obs_id}, 64'd0);
            $display("vector %0d: src=%0d tag=%0d -> cdb_id=%0d tag_err=%0d",
                     i, tbl[i].src, tbl[i].tag, obs_id, tag_err);
        end

        // Contention: add 1, mult 4, ld 6 in the same cycle.
        do_reset();
        cycle(3'b111, {4'd6, 4'd4, 4'd1}, {64'h66, 64'h44, 64'h11}, 1'b0);
        idle(); check("cont_1", {60'd0, obs_id}, 64'd1);
        idle(); check("cont_4", {60'd0, obs_id}, 64'd4);
        idle(); check("cont_6", {60'd0, obs_id}, 64'd6);
        idle(); check("cont_idle", {60'd0, obs_id}, 64'd0);
        check("cont_ready", {61'd0, rdy}, 64'd7);
        $display("contention: sequence 1,4,6 done");

        // Fairness: add offers back to back while ld offers tag 7 once.
        do_reset();
        j = 0; ld_want = 0; ld_acc = -100; ld_b = -100;
        got.delete();
        for (int c = 0; c < 14; c++) begin
            if (c == 1) ld_want = 1;
            v = '0; t = '0; d = '0;
            if (c < 10) begin
                v[0] = 1'b1;
                t[0] = TW'(j % 3 + 1);
                d[0] = DW'(j);
            end
            v[2] = ld_want[0];
            t[2] = 4'd7;
            d[2] = 64'h77;
            cycle(v, t, d, 1'b0);
            if (acc[0]) j++;
            if (acc[2]) begin ld_want = 0; ld_acc = c; end
            if (obs_id == 4'd7) ld_b = c;
            if (obs_id >= 4'd1 && obs_id <= 4'd3) got.push_back(obs_data);
        end
        check("fair_ld_wait", {63'd0, (ld_b - ld_acc >= 1) && (ld_b - ld_acc <= 3)}, 64'd1);
        check("fair_add_count", 64'(got.size()), 64'(j));
        for (int k = 0; k < got.size(); k++) check("fair_add_order", got[k], 64'(k));
        $display("fairness: %0d add results, ld accepted c=%0d broadcast c=%0d", j, ld_acc, ld_b);

        // Flush with three full slots.
        do_reset();
        cycle(3'b111, {4'd8, 4'd5, 4'd3}, {64'h8, 64'h5, 64'h3}, 1'b0);
        cycle(3'b000, '0, '0, 1'b1);
        check("flush_id", {60'd0, obs_id}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            idle();
            check("flush_no_stale", {63'd0, obs_id == 4'd3 || obs_id == 4'd5 || obs_id == 4'd8}, 64'd0);
        end
        check("flush_ready", {61'd0, rdy}, 64'd7);
        $display("flush: pending 3,5,8 discarded");

        // Asynchronous reset between edges with slots pending.
        do_reset();
        cycle(3'b011, {4'd0, 4'd4, 4'd1}, {64'h0, 64'h44, 64'h11}, 1'b0);
        cycle(3'b100, {4'd8, 4'd0, 4'd0}, {64'h88, 64'h0, 64'h0}, 1'b0);
        check("arst_pre", {60'd0, obs_id}, 64'd1);
        #2;
        rst_n = 1'b0;
        vld   = '0;
        #1;
        check("arst_id", {60'd0, cdb_id}, 64'd0);
        check("arst_ready", {61'd0, rdy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            check("arst_no_stale", {63'd0, obs_id == 4'd4 || obs_id == 4'd8}, 64'd0);
        end
        $display("async reset: pending 4,8 discarded");

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = 3'($urandom_range(0, 7));
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(0, 15) == 0) t[s] = TW'($urandom_range(0, 15));
                else t[s] = TW'(LO[s] + int'($urandom_range(0, HI[s] - LO[s])));
                d[s] = {$urandom, $urandom};
            end
            cycle(v, t, d, $urandom_range(0, 19) == 0);
        end
        $display("random: 400 cycles done");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, width of the result data path and cdb_data.
REQ-002 Parameter TAG_W, default 4, width of every tag port; tag encoding comes from the shared package.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 CTRL_flush  input  1  flush from the ROB; discards all pending results.
REQ-006 add_valid  input  1  adder result offered this cycle.
REQ-007 add_tag  input  TAG_W  adder station tag, legal values add_1..add_3 (1..3).
REQ-008 add_data  input  DATA_W  adder result value.
REQ-009 add_ready  output  1  adder holding slot can accept a result this cycle.
REQ-010 mult_valid, mult_tag, mult_data, mult_ready: same directions and widths as REQ-006..009 for the multiplier; legal tags mult_1..mult_2 (4..5).
REQ-011 ld_valid, ld_tag, ld_data, ld_ready: same for the load unit; legal tags ld_1..ld_3 (6..8).
REQ-012 cdb_id  output  TAG_W  broadcast tag; notag (0) when idle.
REQ-013 cdb_data  output  DATA_W  broadcast value; qualified only by cdb_id != notag.
REQ-014 tag_err  output  1  sticky flag; an illegal tag was offered.

Function
REQ-015 The block SHALL hold one single-entry slot per source (add, mult, ld), each with a full bit, tag and data.
REQ-016 A source handshake SHALL complete on a rising edge where valid and ready are both 1; the slot then loads tag/data and sets full.
REQ-017 x_ready SHALL be 1 when slot x is empty, or when slot x is full and granted this cycle; this allows back-to-back results at one per cycle per source.
REQ-018 An offered tag outside the source's legal range, including notag, SHALL be dropped. It SHALL not load the slot and SHALL set tag_err; ready is unaffected.
REQ-019 Each cycle, at most one full slot SHALL be granted, using round-robin in the order add, mult, ld.
REQ-020 The round-robin pointer SHALL move to the source after the granted one; with no grant it SHALL hold.
REQ-021 The granted slot's tag/data SHALL be registered onto cdb_id/cdb_data at the next edge and the slot cleared, unless it was reloaded by REQ-017.
REQ-022 cdb_id SHALL carry each result for exactly one cycle; with no grant, cdb_id SHALL be notag and cdb_data SHALL hold its previous value.
REQ-023 Latency SHALL be: result accepted at edge N; earliest visibility on the CDB is the cycle after edge N+1; with all three slots full, worst-case wait is 2 extra cycles.
REQ-024 CTRL_flush high at an edge SHALL clear all full bits, discard any handshake that cycle, and drive cdb_id to notag; the pointer resets to add; tag_err is unaffected.
REQ-025 All x_ready SHALL be 0 while CTRL_flush is high.
REQ-026 A result SHALL never be broadcast twice and SHALL never be lost except by flush.

Reset
REQ-027 On rst_n low, asynchronously, the block SHALL set:
- all full bits to 0
- cdb_id to notag and cdb_data to 0
- the pointer to add
- tag_err to 0
REQ-028 During reset all x_ready SHALL be 0; after rst_n deasserts, ready follows REQ-017 from the first edge.
REQ-029 Reset asserted mid-operation SHALL discard pending slots without broadcasting them.

Structure
REQ-030 The shared package SHALL hold the tag constants (notag, add_1..3, mult_1..2, ld_1..3, st_1..2), TAG_W and DATA_W, and the per-source legal tag ranges; the ROB and reservation stations use the same package.
REQ-031 The per-source holding slot SHALL be one sub-module, cdb_slot, instantiated three times; arbitration and the output register are in cdb_arbiter.

Verification
REQ-032 Single result: add offers tag 2, data 0x1234 at edge 0 -> cdb_id=2 and cdb_data=0x1234 during the cycle after edge 1 only, then cdb_id=0.
REQ-033 Contention: add tag 1, mult tag 4 and ld tag 6 accepted at the same edge -> the CDB shows 1, 4, 6 on three consecutive cycles; all three ready signals are 1 again after the respective grants.
REQ-034 Fairness: add offers continuously (tags 1,2,3,1...) while ld holds tag 7 -> tag 7 is broadcast within 2 cycles of acceptance, and every add result appears exactly once, in order.
REQ-035 Illegal tag: mult offers tag 9 -> no broadcast, tag_err=1 and stays 1; a following mult tag 5 is broadcast normally.
REQ-036 Flush: slots full with tags 3, 5, 8 and CTRL_flush pulsed at the next edge -> cdb_id=0 afterwards, no tag 3, 5 or 8 ever appears, and ready returns to 1.
REQ-037 Reset mid-operation: rst_n driven low asynchronously between edges with two slots full -> cdb_id=0 immediately; no pending tag appears after release.
